dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the RISC-V core load/store path (port 0) and a DMA/debug master (port 1).
- Sits between the core's ALU-result/store-data nets and the Data_memory instance.
- Arbitrates round-robin, supports DMA burst locking with a bounded hold time, and returns read data one cycle after grant.
- Drives a stall to the core's PC load enable while the core is waiting for the memory.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core, DMA and memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_gnt;
    logic          c_stall;
    logic [DW-1:0] c_rdata;
    logic          c_rvalid;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_lock;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_stall, c_rdata, c_rvalid,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_gnt, d_rdata, d_rvalid,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_stall, c_rdata, c_rvalid,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_gnt, d_rdata, d_rvalid,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin core/DMA data memory arbiter with bounded DMA burst lock
module dmem_arbiter #(
    parameter int AW       = 30,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 8
) (
    input logic          clk,
    input logic          areset,
    dmem_arbiter_if.slave bus
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic          last_gnt_q, last_gnt_d;
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic [DW-1:0] c_rdata_q, c_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          c_rvalid_q, c_rvalid_d;
    logic          d_rvalid_q, d_rvalid_d;

    logic          both_req;
    logic          lock_win;
    logic          c_gnt;
    logic          d_gnt;

    always_comb begin
        both_req = bus.c_req & bus.d_req;
        // DMA keeps the bus only while it owned it last and the core has not waited too long
        lock_win = both_req & last_gnt_q & bus.d_lock & (hold_cnt_q < HOLD_LIM);
        d_gnt    = areset & ((bus.d_req & ~bus.c_req) | lock_win | (both_req & ~last_gnt_q));
        c_gnt    = areset & bus.c_req & ~d_gnt;
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        if (c_gnt) begin
            bus.mem_addr  = bus.c_addr;
            bus.mem_wdata = bus.c_wdata;
            bus.mem_we    = bus.c_we;
        end else if (d_gnt) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_we    = bus.d_we;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (c_gnt) begin
            last_gnt_d = 1'b0;
        end else if (d_gnt) begin
            last_gnt_d = 1'b1;
        end

        // only lock-driven wins count; an uncontended locked grant leaves the count alone
        if (lock_win) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end else if (d_gnt & bus.d_lock) begin
            hold_cnt_d = hold_cnt_q;
        end else begin
            hold_cnt_d = 8'd0;
        end

        c_rvalid_d = c_gnt & ~bus.c_we;
        d_rvalid_d = d_gnt & ~bus.d_we;
        c_rdata_d  = c_rvalid_d ? bus.mem_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? bus.mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            last_gnt_q <= 1'b1;
            hold_cnt_q <= 8'd0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            hold_cnt_q <= hold_cnt_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.c_stall  = bus.c_req & ~c_gnt;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized check of dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
    localparam int AW       = 30;
    localparam int DW       = 32;
    localparam int MAX_HOLD = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .areset (rst_n),
        .bus    (bus)
    );

    // memory the arbiter drives: combinational read, write at the edge
    logic [DW-1:0] env_mem [64];
    logic          env_clr = 1'b1;
    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= '0;
        end else if (bus.mem_we) begin
            env_mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = env_mem[bus.mem_addr[5:0]];

    // behavioural model state
    logic [DW-1:0] ref_mem [64];
    bit            m_last_dma;
    int            m_lock_wins;
    int            m_core_wait;
    bit            e_c_rvalid, e_d_rvalid;
    logic [DW-1:0] e_c_rdata, e_d_rdata;
    bit            obs_cg, obs_dg, obs_stall;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_last_dma  = 1'b1;
        m_lock_wins = 0;
        m_core_wait = 0;
        e_c_rvalid  = 1'b0;
        e_d_rvalid  = 1'b0;
        e_c_rdata   = '0;
        e_d_rdata   = '0;
    endfunction

    // entered at posedge+1 with inputs set; returns at the next posedge+1
    task automatic step();
        bit            gc, gd, lock_reason, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ew;
        #1;
        gc = 1'b0;
        gd = 1'b0;
        lock_reason = 1'b0;
        if (rst_n) begin
            if (bus.c_req && bus.d_req) begin
                lock_reason = m_last_dma && bus.d_lock && (m_lock_wins < MAX_HOLD - 1);
                if (lock_reason || !m_last_dma) gd = 1'b1;
                else                            gc = 1'b1;
            end else begin
                gc = bus.c_req;
                gd = bus.d_req;
            end
        end
        ea  = gc ? bus.c_addr  : gd ? bus.d_addr  : '0;
        ew  = gc ? bus.c_wdata : gd ? bus.d_wdata : '0;
        ewe = gc ? bus.c_we    : gd ? bus.d_we    : 1'b0;
        chk("c_gnt",     bus.c_gnt,     gc);
        chk("d_gnt",     bus.d_gnt,     gd);
        chk("c_stall",   bus.c_stall,   bus.c_req && !gc);
        chk("mem_addr",  bus.mem_addr,  ea);
        chk("mem_wdata", bus.mem_wdata, ew);
        chk("mem_we",    bus.mem_we,    ewe);
        obs_cg    = bus.c_gnt;
        obs_dg    = bus.d_gnt;
        obs_stall = bus.c_stall;
        @(posedge clk);
        e_c_rvalid = gc && !bus.c_we;
        e_d_rvalid = gd && !bus.d_we;
        if (e_c_rvalid) e_c_rdata = ref_mem[bus.c_addr[5:0]];
        if (e_d_rvalid) e_d_rdata = ref_mem[bus.d_addr[5:0]];
        if (ewe) ref_mem[ea[5:0]] = ew;
        if (gc) m_last_dma = 1'b0;
        if (gd) m_last_dma = 1'b1;
        if (lock_reason)              m_lock_wins++;
        else if (!gd || !bus.d_lock)  m_lock_wins = 0;
        if (bus.c_req && !gc) m_core_wait++;
        else                  m_core_wait = 0;
        if (m_core_wait > 0) chk("core_wait_bound", 64'(m_core_wait <= MAX_HOLD), 64'd1);
        #1;
        chk("c_rvalid", bus.c_rvalid, e_c_rvalid);
        chk("d_rvalid", bus.d_rvalid, e_d_rvalid);
        chk("c_rdata",  bus.c_rdata,  e_c_rdata);
        chk("d_rdata",  bus.d_rdata,  e_d_rdata);
    endtask

    task automatic idle_inputs();
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.d_lock = 1'b0;
    endtask

    initial begin
        int lock_pat [10];
        bit cp, dp;
        lock_pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        env_clr = 1'b0;

        // requests during reset must not be granted or write
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1;
        #1;
        chk("rst_c_gnt",    bus.c_gnt,    0);
        chk("rst_d_gnt",    bus.d_gnt,    0);
        chk("rst_mem_we",   bus.mem_we,   0);
        chk("rst_c_rvalid", bus.c_rvalid, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        rst_n = 1'b1;
        step();
        chk("idle_stall",  obs_stall, 0);
        chk("idle_c_gnt",  obs_cg,    0);

        // core write then read of 0x10
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 30'h10; bus.c_wdata = 32'hDEADBEEF;
        step();
        chk("t2_wr_gnt", obs_cg, 1);
        bus.c_we = 1'b0;
        step();
        chk("t2_rd_gnt",    obs_cg,       1);
        chk("t2_rd_rvalid", bus.c_rvalid, 1);
        chk("t2_rd_data",   bus.c_rdata,  32'hDEADBEEF);
        bus.c_req = 1'b0;
        step();
        chk("t2_rvalid_pulse", bus.c_rvalid, 0);

        // fresh reset, then unlocked contention alternates starting with the core
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = AW'($urandom_range(0, 63));
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'($urandom_range(0, 63));
            bus.d_lock = 1'b0;
            step();
            chk("t3_alt_dma",   obs_dg,    64'(i % 2));
            chk("t3_alt_stall", obs_stall, 64'(i % 2));
        end

        // locked burst: one round-robin DMA win, MAX_HOLD-1 locked wins, then the core
        bus.d_req = 1'b0;
        step();
        chk("t4_core_first", obs_cg, 1);
        bus.d_req = 1'b1; bus.d_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_lock_dma", obs_dg, 64'(lock_pat[i]));
        end

        // DMA write then core read of the same word on the next cycle
        idle_inputs();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 30'h20; bus.d_wdata = 32'h0000_00AA;
        step();
        chk("t5_dma_wr_gnt", obs_dg, 1);
        idle_inputs();
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 30'h20;
        step();
        chk("t5_raw_valid", bus.c_rvalid, 1);
        chk("t5_raw_data",  bus.c_rdata,  32'h0000_00AA);

        // reset lands on a granted DMA read while a previous rvalid is still up
        idle_inputs();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h20;
        step();
        chk("t6_prev_rvalid", bus.d_rvalid, 1);
        chk("t6_prev_rdata",  bus.d_rdata,  32'h0000_00AA);
        bus.d_addr = 30'h10;
        #2;
        chk("t6_pre_gnt", bus.d_gnt, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt",    bus.d_gnt,    0);
        chk("t6_rst_we",     bus.mem_we,   0);
        chk("t6_rst_rvalid", bus.d_rvalid, 0);
        model_reset();
        bus.d_req = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rvalid_held", bus.d_rvalid, 0);
        rst_n = 1'b1;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 30'h1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h2; bus.d_lock = 1'b0;
        step();
        chk("t6_core_after_rst", obs_cg, 1);

        // randomized traffic; requesters hold req and payload until granted
        idle_inputs();
        cp = 1'b0;
        dp = 1'b0;
        obs_cg = 1'b0;
        obs_dg = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (cp && obs_cg) cp = 1'b0;
            if (dp && obs_dg) dp = 1'b0;
            if (!cp && $urandom_range(0, 3) != 0) begin
                cp = 1'b1;
                bus.c_we    = 1'($urandom_range(0, 1));
                bus.c_addr  = AW'($urandom_range(0, 7));
                bus.c_wdata = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = AW'($urandom_range(0, 7));
                bus.d_wdata = $urandom;
            end
            bus.c_req  = cp;
            bus.d_req  = dp;
            bus.d_lock = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
